// File: rtl/sum_accumulator_pkg.sv
// rtl/sum_accumulator_pkg.sv - shared state type and default widths for sum_accumulator
package sum_accumulator_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH   = 24;
   localparam int DEFAULT_COUNT_W = 8;

endpackage

// File: rtl/ripple_carry_adder.sv
// rtl/ripple_carry_adder.sv - WIDTH-bit ripple-carry adder with carry in/out
module ripple_carry_adder #(
   parameter int WIDTH = 24
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   // carry is a loop-local variable so the chain stays one combinational block
   always_comb begin
      logic c;
      sum = '0;
      c   = cin;
      for (int i = 0; i < WIDTH; i++) begin
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - frame sum accumulator with valid/ready in and out
// Define SUM_ACCUMULATOR_SATURATE_EN to saturate acc on carry-out instead of wrapping.
module sum_accumulator
   import sum_accumulator_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int COUNT_W = DEFAULT_COUNT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [COUNT_W-1:0] frame_len,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_sum,
   output logic               out_ovf,
   output logic               busy
);

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   acc;
   logic [WIDTH-1:0]   add_sum;
   logic [WIDTH-1:0]   acc_add;
   logic               add_cout;
   logic [COUNT_W-1:0] count;
   logic [COUNT_W-1:0] count_inc;
   logic [COUNT_W-1:0] len_q;
   logic [COUNT_W-1:0] first_len;
   logic               ovf;
   logic               accept;

   ripple_carry_adder #(
      .WIDTH (WIDTH)
   ) u_adder (
      .a    (acc),
      .b    (in_data),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // a zero-length frame behaves as a single-sample frame
   assign first_len = (frame_len == '0) ? COUNT_W'(1) : frame_len;
   assign count_inc = count + COUNT_W'(1);

`ifdef SUM_ACCUMULATOR_SATURATE_EN
   // once saturated, any further add carries out again (or adds 0), so acc stays all-ones
   assign acc_add = add_cout ? '1 : add_sum;
`else
   assign acc_add = add_sum;
`endif

   assign out_sum = rst ? '0 : acc;
   assign out_ovf = rst ? 1'b0 : ovf;

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b1;
      out_valid = 1'b0;
      busy      = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            accept = in_valid;
            if (accept) begin
               state_nxt = (first_len == COUNT_W'(1)) ? HOLD : ACCUM;
            end
         end
         ACCUM: begin
            busy   = 1'b1;
            accept = in_valid;
            if (accept && (count_inc == len_q)) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            in_ready  = 1'b0;
            out_valid = 1'b1;
            busy      = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // outputs look like IDLE while reset is held, even before the first edge
      if (rst) begin
         in_ready  = 1'b1;
         out_valid = 1'b0;
         busy      = 1'b0;
         accept    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc   <= '0;
         count <= '0;
         len_q <= '0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  len_q <= first_len;
                  acc   <= in_data;
                  count <= COUNT_W'(1);
                  ovf   <= 1'b0;
               end
            end
            ACCUM: begin
               if (accept) begin
                  acc   <= acc_add;
                  count <= count_inc;
                  ovf   <= ovf | add_cout;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  acc   <= '0;
                  count <= '0;
                  ovf   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sum_accumulator.sv
// tb/tb_sum_accumulator.sv - directed vector bench for sum_accumulator
module tb_sum_accumulator;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] in_data;
   logic [7:0]  frame_len;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] out_sum;
   logic        out_ovf;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sum_accumulator #(
      .WIDTH   (24),
      .COUNT_W (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .frame_len (frame_len),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_ovf   (out_ovf),
      .busy      (busy)
   );

   typedef struct {
      logic [7:0]       len;
      int               n;
      logic [3:0][23:0] s;
      logic [23:0]      esum;
      logic             eovf;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      in_valid  = 1'b1;
      frame_len = v.len;
      for (int i = 0; i < v.n; i++) begin
         in_data = v.s[i];
         chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
         chk({tag, "_pre_valid"}, 32'(out_valid), 32'd0);
         tick();
         frame_len = 8'hff;
      end
      in_valid = 1'b0;
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_out_sum"}, 32'(out_sum), 32'(v.esum));
      chk({tag, "_out_ovf"}, 32'(out_ovf), 32'(v.eovf));
      chk({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_hold_busy"}, 32'(busy), 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
      chk({tag, "_idle_sum"}, 32'(out_sum), 32'd0);
   endtask

   initial begin
      vecs[0] = '{len: 8'd4, n: 4, s: {24'd4, 24'd3, 24'd2, 24'd1}, esum: 24'd10, eovf: 1'b0};
`ifdef SUM_ACCUMULATOR_SATURATE_EN
      vecs[1] = '{len: 8'd2, n: 2, s: {24'd0, 24'd0, 24'h000002, 24'hffffff}, esum: 24'hffffff, eovf: 1'b1};
      vecs[4] = '{len: 8'd3, n: 3, s: {24'd0, 24'h000005, 24'h800000, 24'h800000}, esum: 24'hffffff, eovf: 1'b1};
`else
      vecs[1] = '{len: 8'd2, n: 2, s: {24'd0, 24'd0, 24'h000002, 24'hffffff}, esum: 24'h000001, eovf: 1'b1};
      vecs[4] = '{len: 8'd3, n: 3, s: {24'd0, 24'h000005, 24'h800000, 24'h800000}, esum: 24'h000005, eovf: 1'b1};
`endif
      vecs[2] = '{len: 8'd0, n: 1, s: {24'd0, 24'd0, 24'd0, 24'd7}, esum: 24'd7, eovf: 1'b0};
      vecs[3] = '{len: 8'd1, n: 1, s: {24'd0, 24'd0, 24'd0, 24'd5}, esum: 24'd5, eovf: 1'b0};
      vecs[5] = '{len: 8'd2, n: 2, s: {24'd0, 24'd0, 24'h000200, 24'h000100}, esum: 24'h000300, eovf: 1'b0};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      frame_len = '0;
      out_ready = 1'b0;
      #1;
      chk("rst_async_view_valid", 32'(out_valid), 32'd0);
      chk("rst_async_view_ready", 32'(in_ready), 32'd1);
      tick();
      tick();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_sum", 32'(out_sum), 32'd0);
      chk("rst_ovf", 32'(out_ovf), 32'd0);
      rst = 1'b0;
      tick();

      for (int k = 0; k < 6; k++) begin
         run_frame(vecs[k], k);
      end

      // zero-length frame held in HOLD while downstream stalls
      in_valid  = 1'b1;
      frame_len = 8'd0;
      in_data   = 24'd7;
      tick();
      in_data = 24'd99;
      for (int c = 0; c < 5; c++) begin
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_sum", 32'(out_sum), 32'd7);
         chk("stall_ready", 32'(in_ready), 32'd0);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("stall_release_valid", 32'(out_valid), 32'd0);
      chk("stall_release_ready", 32'(in_ready), 32'd1);

      // reset mid-frame wins over a concurrent sample
      in_valid  = 1'b1;
      frame_len = 8'd3;
      in_data   = 24'd4;
      tick();
      in_data = 24'd6;
      tick();
      chk("midrst_busy_before", 32'(busy), 32'd1);
      rst     = 1'b1;
      in_data = 24'd100;
      tick();
      rst      = 1'b0;
      in_valid = 1'b0;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_sum", 32'(out_sum), 32'd0);
      in_valid  = 1'b1;
      frame_len = 8'd1;
      in_data   = 24'd5;
      tick();
      in_valid = 1'b0;
      chk("after_rst_valid", 32'(out_valid), 32'd1);
      chk("after_rst_sum", 32'(out_sum), 32'd5);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // reset in HOLD beats the output handshake
      in_valid  = 1'b1;
      frame_len = 8'd1;
      in_data   = 24'd9;
      tick();
      in_valid = 1'b0;
      chk("holdrst_pre_valid", 32'(out_valid), 32'd1);
      rst       = 1'b1;
      out_ready = 1'b1;
      tick();
      rst       = 1'b0;
      out_ready = 1'b0;
      chk("holdrst_valid", 32'(out_valid), 32'd0);
      chk("holdrst_sum", 32'(out_sum), 32'd0);
      chk("holdrst_busy", 32'(busy), 32'd0);

      // gaps between samples and frame_len changed mid-frame
      in_valid  = 1'b1;
      frame_len = 8'd3;
      in_data   = 24'd10;
      tick();
      in_valid  = 1'b0;
      frame_len = 8'd1;
      tick();
      chk("gap_busy", 32'(busy), 32'd1);
      chk("gap_sum_hold", 32'(out_sum), 32'd10);
      tick();
      in_valid  = 1'b1;
      frame_len = 8'd2;
      in_data   = 24'd20;
      tick();
      in_valid = 1'b0;
      chk("gap_mid_valid", 32'(out_valid), 32'd0);
      chk("gap_mid_sum", 32'(out_sum), 32'd30);
      tick();
      in_valid = 1'b1;
      in_data  = 24'd30;
      tick();
      in_valid = 1'b0;
      chk("gap_valid", 32'(out_valid), 32'd1);
      chk("gap_sum", 32'(out_sum), 32'd60);
      chk("gap_ovf", 32'(out_ovf), 32'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("gap_idle", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
